// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller:
// bypass-select encodings and the register-index width helper.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  function automatic int hs_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard controller: stage register/control
// inputs and the stall, bypass and mult/div status outputs.
interface hazard_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic [AW-1:0]    rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic             uses_rs_d, uses_rt_d, branch_d, md_op_d, md_read_d;
  logic             reg_write_e, mem_to_reg_e, md_start_e;
  logic             reg_write_m, mem_to_reg_m, reg_write_w;
  logic             stall_f, stall_d, flush_e, forward_ad, forward_bd;
  logic [1:0]       forward_ae, forward_be;
  logic             md_busy, md_done;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  rs_d, rt_d, uses_rs_d, uses_rt_d, branch_d, md_op_d, md_read_d,
    input  rs_e, rt_e, write_reg_e, reg_write_e, mem_to_reg_e, md_start_e,
    input  write_reg_m, reg_write_m, mem_to_reg_m, write_reg_w, reg_write_w,
    output stall_f, stall_d, flush_e, forward_ad, forward_bd,
    output forward_ae, forward_be, md_busy, md_done, stall_cycles
  );

  modport master (
    output rs_d, rt_d, uses_rs_d, uses_rt_d, branch_d, md_op_d, md_read_d,
    output rs_e, rt_e, write_reg_e, reg_write_e, mem_to_reg_e, md_start_e,
    output write_reg_m, reg_write_m, mem_to_reg_m, write_reg_w, reg_write_w,
    input  stall_f, stall_d, flush_e, forward_ad, forward_bd,
    input  forward_ae, forward_be, md_busy, md_done, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_md_scoreboard.sv
// Busy tracker for the multi-cycle HI/LO unit: a down-counter loaded on
// issue, with registered busy and a one-cycle done pulse when it drains.
module md_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  output logic md_busy,
  output logic md_done
);

  localparam int            CW     = hs_clog2(MD_LAT + 1);
  localparam logic [CW-1:0] LAT_C  = CW'(MD_LAT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          md_busy_d, md_busy_q;
  logic          md_done_d, md_done_q;

  // Next-state: a start is accepted only when idle; a busy unit keeps draining.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == ZERO_C) begin
      if (md_start) begin
        cnt_d = LAT_C;
      end else begin
        cnt_d = ZERO_C;
      end
    end else begin
      cnt_d = cnt_q - ONE_C;
    end
    md_busy_d = (cnt_d != ZERO_C);
    md_done_d = (cnt_q != ZERO_C) && (cnt_d == ZERO_C);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= ZERO_C;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
      md_done_q <= md_done_d;
    end
  end

  assign md_busy = md_busy_q;
  assign md_done = md_done_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the 5-stage pipeline: bypass selects,
// load-use/branch/mult-div stalls and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);

  localparam int               AW      = hs_clog2(NREGS);
  localparam logic [AW-1:0]    R0_C    = AW'(0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             lwstall_s, brstall_s, mdstall_s, stall_s;
  logic             md_busy_s, md_done_s;
  logic             forward_ad_s, forward_bd_s;
  logic [1:0]       forward_ae_s, forward_be_s;
  logic [CNT_W-1:0] stall_cycles_d, stall_cycles_q;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && (a != R0_C);
  endfunction

  function automatic logic src_hit(input logic [AW-1:0] r, input logic [AW-1:0] rs,
                                   input logic [AW-1:0] rt, input logic urs, input logic urt);
    return (reg_hit(r, rs) && urs) || (reg_hit(r, rt) && urt);
  endfunction

  // Bypass selects and hazard detection.
  always_comb begin
    if (hz.reg_write_m && reg_hit(hz.write_reg_m, hz.rs_e)) begin
      forward_ae_s = FWD_MEM;
    end else if (hz.reg_write_w && reg_hit(hz.write_reg_w, hz.rs_e)) begin
      forward_ae_s = FWD_WB;
    end else begin
      forward_ae_s = FWD_RF;
    end
    if (hz.reg_write_m && reg_hit(hz.write_reg_m, hz.rt_e)) begin
      forward_be_s = FWD_MEM;
    end else if (hz.reg_write_w && reg_hit(hz.write_reg_w, hz.rt_e)) begin
      forward_be_s = FWD_WB;
    end else begin
      forward_be_s = FWD_RF;
    end
    forward_ad_s = hz.reg_write_m && reg_hit(hz.write_reg_m, hz.rs_d);
    forward_bd_s = hz.reg_write_m && reg_hit(hz.write_reg_m, hz.rt_d);
    lwstall_s = hz.mem_to_reg_e &&
                src_hit(hz.write_reg_e, hz.rs_d, hz.rt_d, hz.uses_rs_d, hz.uses_rt_d);
    brstall_s = hz.branch_d &&
                ((hz.reg_write_e &&
                  src_hit(hz.write_reg_e, hz.rs_d, hz.rt_d, hz.uses_rs_d, hz.uses_rt_d)) ||
                 (hz.mem_to_reg_m &&
                  src_hit(hz.write_reg_m, hz.rs_d, hz.rt_d, hz.uses_rs_d, hz.uses_rt_d)));
    mdstall_s = (md_busy_s || hz.md_start_e) && (hz.md_op_d || hz.md_read_d);
    stall_s   = lwstall_s || brstall_s || mdstall_s;
  end

  // Stall-cycle counter next value, pinned at all-ones.
  always_comb begin
    if (stall_s && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  md_scoreboard #(.MD_LAT(MD_LAT)) u_md (
    .clk      (clk),
    .reset    (reset),
    .md_start (hz.md_start_e),
    .md_busy  (md_busy_s),
    .md_done  (md_done_s)
  );

  assign hz.stall_f      = stall_s;
  assign hz.stall_d      = stall_s;
  assign hz.flush_e      = stall_s;
  assign hz.forward_ad   = forward_ad_s;
  assign hz.forward_bd   = forward_bd_s;
  assign hz.forward_ae   = forward_ae_s;
  assign hz.forward_be   = forward_be_s;
  assign hz.md_busy      = md_busy_s;
  assign hz.md_done      = md_done_s;
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: forwarding, stalls, mult/div
// scoreboard timing, reset mid-operation and counter saturation.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int AW    = 5;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             stall;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_if #(.AW(AW), .CNT_W(CNT_W)) hz  ();
  hazard_if #(.AW(AW), .CNT_W(CNT_W)) hz1 ();

  hazard_scoreboard #(.NREGS(32), .MD_LAT(4), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .hz(hz));
  hazard_scoreboard #(.NREGS(32), .MD_LAT(1), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .reset(reset), .hz(hz1));

  task automatic clear_inputs();
    hz.rs_d = 5'd0; hz.rt_d = 5'd0; hz.rs_e = 5'd0; hz.rt_e = 5'd0;
    hz.write_reg_e = 5'd0; hz.write_reg_m = 5'd0; hz.write_reg_w = 5'd0;
    hz.uses_rs_d = 1'b0; hz.uses_rt_d = 1'b0; hz.branch_d = 1'b0;
    hz.md_op_d = 1'b0; hz.md_read_d = 1'b0; hz.reg_write_e = 1'b0;
    hz.mem_to_reg_e = 1'b0; hz.md_start_e = 1'b0; hz.reg_write_m = 1'b0;
    hz.mem_to_reg_m = 1'b0; hz.reg_write_w = 1'b0;
    hz1.rs_d = 5'd0; hz1.rt_d = 5'd0; hz1.rs_e = 5'd0; hz1.rt_e = 5'd0;
    hz1.write_reg_e = 5'd0; hz1.write_reg_m = 5'd0; hz1.write_reg_w = 5'd0;
    hz1.uses_rs_d = 1'b0; hz1.uses_rt_d = 1'b0; hz1.branch_d = 1'b0;
    hz1.md_op_d = 1'b0; hz1.md_read_d = 1'b0; hz1.reg_write_e = 1'b0;
    hz1.mem_to_reg_e = 1'b0; hz1.md_start_e = 1'b0; hz1.reg_write_m = 1'b0;
    hz1.mem_to_reg_m = 1'b0; hz1.reg_write_w = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if ({hz.stall_f, hz.stall_d, hz.flush_e} !== 3'b000) begin n_bad++; $display("FAIL reset_stall: got %b expected 000", {hz.stall_f, hz.stall_d, hz.flush_e}); end
    n_cmp++; if ({hz.forward_ad, hz.forward_bd, hz.forward_ae, hz.forward_be} !== 6'b0) begin n_bad++; $display("FAIL reset_fwd: got %b expected 000000", {hz.forward_ad, hz.forward_bd, hz.forward_ae, hz.forward_be}); end
    n_cmp++; if ({hz.md_busy, hz.md_done} !== 2'b00) begin n_bad++; $display("FAIL reset_md: got %b expected 00", {hz.md_busy, hz.md_done}); end
    n_cmp++; if (hz.stall_cycles !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", hz.stall_cycles); end
  endtask

  task automatic test_ex_bypass();
    tick(); clear_inputs();
    hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd5; hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd5;
    hz.rs_e = 5'd5; hz.rt_e = 5'd5;
    @(negedge clk);
    n_cmp++; if (hz.forward_ae !== 2'b10) begin n_bad++; $display("FAIL fwd_ae_mem: got %b expected 10", hz.forward_ae); end
    n_cmp++; if (hz.forward_be !== 2'b10) begin n_bad++; $display("FAIL fwd_be_mem: got %b expected 10", hz.forward_be); end
    tick(); hz.reg_write_m = 1'b0;
    @(negedge clk);
    n_cmp++; if (hz.forward_ae !== 2'b01) begin n_bad++; $display("FAIL fwd_ae_wb: got %b expected 01", hz.forward_ae); end
    tick(); hz.rt_e = 5'd7; hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd7; hz.write_reg_w = 5'd9;
    @(negedge clk);
    n_cmp++; if ({hz.forward_ae, hz.forward_be} !== 4'b0010) begin n_bad++; $display("FAIL fwd_split: got %b expected 0010", {hz.forward_ae, hz.forward_be}); end
    tick(); hz.rs_e = 5'd0; hz.rt_e = 5'd0; hz.write_reg_m = 5'd0; hz.write_reg_w = 5'd0;
    hz.rs_d = 5'd0; hz.rt_d = 5'd0;
    @(negedge clk);
    n_cmp++; if ({hz.forward_ae, hz.forward_be, hz.forward_ad, hz.forward_bd} !== 6'b0) begin n_bad++; $display("FAIL fwd_r0: got %b expected 000000", {hz.forward_ae, hz.forward_be, hz.forward_ad, hz.forward_bd}); end
  endtask

  task automatic test_load_use();
    tick(); clear_inputs();
    hz.mem_to_reg_e = 1'b1; hz.write_reg_e = 5'd8; hz.rt_d = 5'd8; hz.uses_rt_d = 1'b1;
    @(negedge clk);
    n_cmp++; if ({hz.stall_f, hz.stall_d, hz.flush_e} !== 3'b111) begin n_bad++; $display("FAIL lwstall: got %b expected 111", {hz.stall_f, hz.stall_d, hz.flush_e}); end
    tick(); hz.uses_rt_d = 1'b0;
    @(negedge clk);
    n_cmp++; if ({hz.stall_f, hz.stall_d, hz.flush_e} !== 3'b000) begin n_bad++; $display("FAIL lw_unused: got %b expected 000", {hz.stall_f, hz.stall_d, hz.flush_e}); end
    tick(); hz.rt_d = 5'd0; hz.rs_d = 5'd8; hz.uses_rs_d = 1'b1;
    @(negedge clk);
    n_cmp++; if (hz.stall_d !== 1'b1) begin n_bad++; $display("FAIL lw_rs: got %b expected 1", hz.stall_d); end
    tick(); hz.write_reg_e = 5'd0; hz.rs_d = 5'd0;
    @(negedge clk);
    n_cmp++; if (hz.stall_d !== 1'b0) begin n_bad++; $display("FAIL lw_r0: got %b expected 0", hz.stall_d); end
  endtask

  task automatic test_branch();
    tick(); clear_inputs();
    hz.branch_d = 1'b1; hz.rs_d = 5'd3; hz.uses_rs_d = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd3;
    @(negedge clk);
    n_cmp++; if ({hz.stall_d, hz.forward_ad} !== 2'b10) begin n_bad++; $display("FAIL br_ex: got %b expected 10", {hz.stall_d, hz.forward_ad}); end
    tick(); hz.reg_write_e = 1'b0; hz.write_reg_e = 5'd0;
    hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd3; hz.mem_to_reg_m = 1'b0;
    @(negedge clk);
    n_cmp++; if ({hz.stall_d, hz.forward_ad} !== 2'b01) begin n_bad++; $display("FAIL br_fwd: got %b expected 01", {hz.stall_d, hz.forward_ad}); end
    tick(); hz.mem_to_reg_m = 1'b1;
    @(negedge clk);
    n_cmp++; if (hz.stall_d !== 1'b1) begin n_bad++; $display("FAIL br_memload: got %b expected 1", hz.stall_d); end
    tick(); hz.branch_d = 1'b0; hz.rt_d = 5'd3;
    @(negedge clk);
    n_cmp++; if ({hz.stall_d, hz.forward_bd} !== 2'b01) begin n_bad++; $display("FAIL nobr: got %b expected 01", {hz.stall_d, hz.forward_bd}); end
  endtask

  task automatic test_md_latency();
    exp_t e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      e.busy = (c >= 1 && c <= 4); e.done = (c == 5); e.stall = (c <= 4);
      e.cnt = (c <= 5) ? CNT_W'(c) : 4'd5;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 7; c++) begin
      tick(); hz.md_start_e = (c == 0); hz.md_read_d = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (hz.md_busy !== e.busy) begin n_bad++; $display("FAIL md_busy c%0d: got %b expected %b", c, hz.md_busy, e.busy); end
      n_cmp++; if (hz.md_done !== e.done) begin n_bad++; $display("FAIL md_done c%0d: got %b expected %b", c, hz.md_done, e.done); end
      n_cmp++; if (hz.stall_d !== e.stall) begin n_bad++; $display("FAIL md_stall c%0d: got %b expected %b", c, hz.stall_d, e.stall); end
      n_cmp++; if (hz.stall_cycles !== e.cnt) begin n_bad++; $display("FAIL md_cnt c%0d: got %0d expected %0d", c, hz.stall_cycles, e.cnt); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      e.busy = (c >= 1 && c <= 4); e.done = (c == 5); e.stall = (c == 3);
      e.cnt = (c <= 3) ? 4'd0 : 4'd1;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 8; c++) begin
      tick(); hz.md_start_e = (c == 0 || c == 2); hz.md_op_d = (c == 3 || c == 6);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (hz.md_busy !== e.busy) begin n_bad++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, hz.md_busy, e.busy); end
      n_cmp++; if (hz.md_done !== e.done) begin n_bad++; $display("FAIL b2b_done c%0d: got %b expected %b", c, hz.md_done, e.done); end
      n_cmp++; if (hz.stall_d !== e.stall) begin n_bad++; $display("FAIL b2b_stall c%0d: got %b expected %b", c, hz.stall_d, e.stall); end
      n_cmp++; if (hz.stall_cycles !== e.cnt) begin n_bad++; $display("FAIL b2b_cnt c%0d: got %0d expected %0d", c, hz.stall_cycles, e.cnt); end
    end
  endtask

  task automatic test_md_lat1();
    exp_t e;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      e.busy = (c == 1); e.done = (c == 2); e.stall = 1'b0; e.cnt = 4'd0;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 4; c++) begin
      tick(); hz1.md_start_e = (c == 0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if ({hz1.md_busy, hz1.md_done} !== {e.busy, e.done}) begin n_bad++; $display("FAIL lat1 c%0d: got %b expected %b", c, {hz1.md_busy, hz1.md_done}, {e.busy, e.done}); end
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    tick(); hz.md_start_e = 1'b1; hz.md_read_d = 1'b1;
    tick(); hz.md_start_e = 1'b0;
    tick(); reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({hz.md_busy, hz.stall_cycles} !== {1'b1, 4'd2}) begin n_bad++; $display("FAIL pre_rst: got %b/%0d expected 1/2", hz.md_busy, hz.stall_cycles); end
    tick(); reset = 1'b0; hz.md_read_d = 1'b0;
    @(negedge clk);
    n_cmp++; if ({hz.md_busy, hz.md_done, hz.stall_cycles} !== 6'b0) begin n_bad++; $display("FAIL rst_mid: got %b/%b/%0d expected 0/0/0", hz.md_busy, hz.md_done, hz.stall_cycles); end
    for (int c = 4; c < 8; c++) begin
      tick();
      @(negedge clk);
      n_cmp++; if ({hz.md_busy, hz.md_done} !== 2'b00) begin n_bad++; $display("FAIL rst_nodone c%0d: got %b expected 00", c, {hz.md_busy, hz.md_done}); end
    end
  endtask

  task automatic test_dual_stall();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick(); hz.md_start_e = (c == 0); hz.md_read_d = 1'b1;
      hz.mem_to_reg_e = 1'b1; hz.write_reg_e = 5'd8; hz.rt_d = 5'd8; hz.uses_rt_d = 1'b1;
    end
    tick(); clear_inputs();
    @(negedge clk);
    n_cmp++; if (hz.stall_cycles !== 4'd3) begin n_bad++; $display("FAIL dual_cnt: got %0d expected 3", hz.stall_cycles); end
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      e.busy = 1'b0; e.done = 1'b0; e.stall = (k < 20);
      e.cnt = (k < 15) ? CNT_W'(k) : 4'd15;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 21; k++) begin
      tick();
      hz.mem_to_reg_e = (k < 20); hz.write_reg_e = 5'd8; hz.rt_d = 5'd8; hz.uses_rt_d = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if ({hz.stall_d, hz.stall_cycles} !== {e.stall, e.cnt}) begin n_bad++; $display("FAIL sat k%0d: got %b/%0d expected %b/%0d", k, hz.stall_d, hz.stall_cycles, e.stall, e.cnt); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_ex_bypass();
    test_load_use();
    test_branch();
    test_md_latency();
    test_back_to_back();
    test_md_lat1();
    test_reset_mid_op();
    test_dual_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
